// File: rtl/nibble_sram_burst.sv
// nibble_sram_burst
//   Word-addressed SRAM reached over a narrow NW-bit bus. Addresses and data
//   move in beats, low beat first. An auto-incrementing pointer supports
//   burst reads and writes. A READ after any other command, or an ADDR/WRITE
//   after a different command, restarts the beat sequence and drops any
//   partial word or address. IDLE only pauses: the beat count and the
//   temporaries hold.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (memory contents are kept)
//   cmd        00 IDLE, 01 WRITE, 10 READ, 11 ADDR; sampled every edge
//   bus_in     address/data beat
//   bus_out    read beat, forced to 0 while out_valid is low
//   out_valid  bus_out carries a read beat
//   busy       a multi-beat transfer is part way through
module nibble_sram_burst #(
  parameter int NW    = 4,
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cmd,
  input  logic [NW-1:0] bus_in,
  output logic [NW-1:0] bus_out,
  output logic          out_valid,
  output logic          busy
);

  localparam int BEATS  = DW / NW;
  localparam int ABEATS = (AW + NW - 1) / NW;
  localparam int BMAX   = (BEATS > ABEATS) ? BEATS : ABEATS;
  localparam int BW     = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_ADDR  = 2'b11;

  logic [AW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [1:0]    last_cmd_q, last_cmd_d;
  logic [AW-1:0] addr_tmp_q, addr_tmp_d;
  logic [DW-1:0] wr_tmp_q, wr_tmp_d;
  logic [DW-1:0] rd_shift_q, rd_shift_d;
  logic          out_valid_q, out_valid_d;

  logic [BW-1:0] cur_beat;
  logic [AW-1:0] ptr_inc;
  logic          mem_we;

  logic [DW-1:0] mem [DEPTH];

  // Pointer advance with explicit wrap so a non power-of-two DEPTH still
  // wraps at DEPTH-1.
  assign ptr_inc = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);

  always_comb begin
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    last_cmd_d  = last_cmd_q;
    addr_tmp_d  = addr_tmp_q;
    wr_tmp_d    = wr_tmp_q;
    rd_shift_d  = rd_shift_q;
    out_valid_d = 1'b0;
    mem_we      = 1'b0;

    // A change of command restarts the sequence before this edge's action.
    // IDLE never counts as a change, so it behaves as a pause.
    cur_beat = beat_q;
    if (cmd != CMD_IDLE && cmd != last_cmd_q) begin
      cur_beat = '0;
    end
    if (cmd != CMD_IDLE) begin
      last_cmd_d = cmd;
    end

    case (cmd)
      CMD_ADDR: begin
        // Bit-wise slice update: AW need not be a multiple of NW, so the
        // top beat may only partly land in addr_tmp (excess bits dropped).
        for (int i = 0; i < AW; i++) begin
          if (i / NW == int'(cur_beat)) begin
            addr_tmp_d[i] = bus_in[i % NW];
          end
        end
        if (int'(cur_beat) == ABEATS - 1) begin
          ptr_d  = addr_tmp_d;
          beat_d = '0;
        end else begin
          beat_d = cur_beat + BW'(1);
        end
      end
      CMD_WRITE: begin
        wr_tmp_d[int'(cur_beat)*NW +: NW] = bus_in;
        if (int'(cur_beat) == BEATS - 1) begin
          mem_we = 1'b1;
          ptr_d  = ptr_inc;
          beat_d = '0;
        end else begin
          beat_d = cur_beat + BW'(1);
        end
      end
      CMD_READ: begin
        out_valid_d = 1'b1;
        if (cur_beat == '0) begin
          rd_shift_d = mem[ptr_q];
        end else begin
          rd_shift_d = rd_shift_q >> NW;
        end
        if (int'(cur_beat) == BEATS - 1) begin
          ptr_d  = ptr_inc;
          beat_d = '0;
        end else begin
          beat_d = cur_beat + BW'(1);
        end
      end
      default: begin
        // IDLE: everything holds, read strobe drops.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      beat_q      <= '0;
      last_cmd_q  <= CMD_IDLE;
      addr_tmp_q  <= '0;
      wr_tmp_q    <= '0;
      rd_shift_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      last_cmd_q  <= last_cmd_d;
      addr_tmp_q  <= addr_tmp_d;
      wr_tmp_q    <= wr_tmp_d;
      rd_shift_q  <= rd_shift_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array has no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= wr_tmp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bus_out   = out_valid_q ? rd_shift_q[NW-1:0] : '0;
  assign busy      = (beat_q != '0);

endmodule

// File: tb/tb_nibble_sram_burst.sv
module tb_nibble_sram_burst;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] W = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] A = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cmd_a = I, cmd_b = I;
  logic [3:0] din_a = '0, din_b = '0;
  logic [3:0] out_a, out_b;
  logic       val_a, val_b, busy_a, busy_b;

  // Default geometry: 4-bit beats, 8-bit words, 16 words.
  nibble_sram_burst #(.NW(4), .DW(8), .AW(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_a), .bus_in(din_a),
    .bus_out(out_a), .out_valid(val_a), .busy(busy_a)
  );

  // Wide geometry: 4 data beats, 2 address beats.
  nibble_sram_burst #(.NW(4), .DW(16), .AW(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_b), .bus_in(din_b),
    .bus_out(out_b), .out_valid(val_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model for dut_a: pending beats collected in a small list,
  // words assembled / split with plain arithmetic.
  logic [7:0] m_mem [16];
  int         m_ptr;
  int         m_cnt;
  logic [1:0] m_last;
  logic [3:0] m_acc [2];
  logic [7:0] m_word;
  logic       m_valid;
  logic [3:0] m_out;

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_last = I; m_valid = 1'b0; m_out = '0; m_word = '0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic [3:0] d);
    if (c != I && c != m_last) m_cnt = 0;
    if (c != I) m_last = c;
    m_valid = (c == R);
    m_out = '0;
    case (c)
      A: begin
        m_ptr = int'(d) % 16;
        m_cnt = 0;
      end
      W: begin
        m_acc[m_cnt] = d;
        m_cnt++;
        if (m_cnt == 2) begin
          m_mem[m_ptr] = m_acc[1] * 16 + m_acc[0];
          m_ptr = (m_ptr + 1) % 16;
          m_cnt = 0;
        end
      end
      R: begin
        if (m_cnt == 0) m_word = m_mem[m_ptr];
        m_out = 4'((m_word >> (4 * m_cnt)) & 8'h0F);
        m_cnt++;
        if (m_cnt == 2) begin
          m_ptr = (m_ptr + 1) % 16;
          m_cnt = 0;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // leave the caller 1 time unit after the edge for sampling.
  task automatic cyc(input logic [1:0] ca, input logic [3:0] da,
                     input logic [1:0] cb, input logic [3:0] db);
    @(negedge clk);
    cmd_a = ca; din_a = da; cmd_b = cb; din_b = db;
    @(posedge clk);
    model_step(ca, da);
    #1;
  endtask

  task automatic chk_b(input string name, input logic v, input logic [3:0] o, input logic b);
    chk({name, ".valid"}, 32'(val_b), 32'(v));
    chk({name, ".out"},   32'(out_b), 32'(o));
    chk({name, ".busy"},  32'(busy_b), 32'(b));
  endtask

  typedef struct {
    logic [1:0] c;
    logic [3:0] d;
    logic       v;
    logic [3:0] o;
    logic       b;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [1:0] c, input logic [3:0] d,
                     input logic v, input logic [3:0] o, input logic b);
    vec_t e;
    e.c = c; e.d = d; e.v = v; e.o = o; e.b = b;
    vt.push_back(e);
  endtask

  initial begin
    logic [1:0] rc;
    logic [3:0] rd;

    // Write/read, then a write at the post-read pointer (4).
    add(A, 4'h3, 0, 0, 0); add(W, 4'h5, 0, 0, 1); add(W, 4'hA, 0, 0, 0);
    add(A, 4'h3, 0, 0, 0); add(R, 0, 1, 4'h5, 1); add(R, 0, 1, 4'hA, 0);
    add(W, 4'hC, 0, 0, 1); add(W, 4'hD, 0, 0, 0);
    add(A, 4'h4, 0, 0, 0); add(R, 0, 1, 4'hC, 1); add(R, 0, 1, 4'hD, 0);
    add(I, 0, 0, 0, 0);
    // Burst wrap F -> 0 -> 1 on both write and read.
    add(A, 4'hF, 0, 0, 0);
    add(W, 4'h1, 0, 0, 1); add(W, 4'h1, 0, 0, 0);
    add(W, 4'h2, 0, 0, 1); add(W, 4'h2, 0, 0, 0);
    add(W, 4'h3, 0, 0, 1); add(W, 4'h3, 0, 0, 0);
    add(A, 4'hF, 0, 0, 0);
    add(R, 0, 1, 4'h1, 1); add(R, 0, 1, 4'h1, 0);
    add(R, 0, 1, 4'h2, 1); add(R, 0, 1, 4'h2, 0);
    add(R, 0, 1, 4'h3, 1); add(R, 0, 1, 4'h3, 0);
    add(I, 0, 0, 0, 0);
    // Abort: half-written word at 2 is discarded by a READ.
    add(A, 4'h2, 0, 0, 0); add(W, 4'h6, 0, 0, 1); add(W, 4'h9, 0, 0, 0);
    add(A, 4'h2, 0, 0, 0); add(W, 4'h7, 0, 0, 1);
    add(R, 0, 1, 4'h6, 1); add(R, 0, 1, 4'h9, 0);
    add(I, 0, 0, 0, 0);
    // Pause inside a write and inside a read.
    add(A, 4'h4, 0, 0, 0); add(W, 4'h1, 0, 0, 1);
    add(I, 0, 0, 0, 1); add(I, 0, 0, 0, 1); add(I, 0, 0, 0, 1);
    add(W, 4'h2, 0, 0, 0);
    add(A, 4'h4, 0, 0, 0); add(R, 0, 1, 4'h1, 1); add(I, 0, 0, 0, 1);
    add(R, 0, 1, 4'h2, 0);
    // ADDR aborts a partial write.
    add(A, 4'h5, 0, 0, 0); add(W, 4'hE, 0, 0, 1); add(A, 4'h6, 0, 0, 0);
    add(W, 4'hF, 0, 0, 1); add(W, 4'hF, 0, 0, 0);
    add(A, 4'h6, 0, 0, 0); add(R, 0, 1, 4'hF, 1); add(R, 0, 1, 4'hF, 0);
    add(I, 0, 0, 0, 0);

    // Reset state, observed while reset is held.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a.valid", 32'(val_a), 0);
    chk("rst.a.out",   32'(out_a), 0);
    chk("rst.a.busy",  32'(busy_a), 0);
    chk_b("rst.b", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed vectors on dut_a.
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].c, vt[i].d, I, 0);
      chk($sformatf("vec%0d.valid", i), 32'(val_a), 32'(vt[i].v));
      chk($sformatf("vec%0d.out", i),   32'(out_a), 32'(vt[i].o));
      chk($sformatf("vec%0d.busy", i),  32'(busy_a), 32'(vt[i].b));
    end

    // Reset mid-write: pointer set to 9, one beat written, then reset.
    cyc(A, 4'h9, I, 0);
    cyc(W, 4'h7, I, 0);
    chk("rstw.busy_before", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk("rstw.busy",  32'(busy_a), 0);
    chk("rstw.valid", 32'(val_a), 0);
    chk("rstw.out",   32'(out_a), 0);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc(W, 4'h1, I, 0); chk("rstw.w1.busy", 32'(busy_a), 1);
    cyc(W, 4'h2, I, 0); chk("rstw.w2.busy", 32'(busy_a), 0);
    cyc(A, 4'h0, I, 0);
    cyc(R, 0, I, 0); chk("rstw.r0", 32'(out_a), 4'h1);
    cyc(R, 0, I, 0); chk("rstw.r1", 32'(out_a), 4'h2);
    // Reset while a read beat is on the bus.
    cyc(R, 0, I, 0);
    chk("rstr.valid_before", 32'(val_a), 1);
    chk("rstr.out_before",   32'(out_a), 4'h3);
    rst_n = 1'b0;
    #1;
    chk("rstr.valid", 32'(val_a), 0);
    chk("rstr.out",   32'(out_a), 0);
    chk("rstr.busy",  32'(busy_a), 0);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Wide instance: two address beats, four data beats.
    cyc(I, 0, A, 4'hA); chk_b("b.a0", 0, 0, 1);
    cyc(I, 0, A, 4'h2); chk_b("b.a1", 0, 0, 0);
    cyc(I, 0, W, 4'h1); chk_b("b.w0", 0, 0, 1);
    cyc(I, 0, W, 4'h2); chk_b("b.w1", 0, 0, 1);
    cyc(I, 0, W, 4'h3); chk_b("b.w2", 0, 0, 1);
    cyc(I, 0, W, 4'h4); chk_b("b.w3", 0, 0, 0);
    cyc(I, 0, A, 4'hA);
    cyc(I, 0, A, 4'h2);
    cyc(I, 0, R, 0); chk_b("b.r0", 1, 4'h1, 1);
    cyc(I, 0, R, 0); chk_b("b.r1", 1, 4'h2, 1);
    cyc(I, 0, R, 0); chk_b("b.r2", 1, 4'h3, 1);
    cyc(I, 0, R, 0); chk_b("b.r3", 1, 4'h4, 0);
    cyc(I, 0, I, 0); chk_b("b.idle", 0, 0, 0);
    // Partial address (first beat only) must leave the pointer at 0x2A.
    cyc(I, 0, A, 4'hA);
    cyc(I, 0, A, 4'h2);
    cyc(I, 0, A, 4'h7); chk_b("b.apart", 0, 0, 1);
    cyc(I, 0, R, 0); chk_b("b.pr0", 1, 4'h1, 1);
    cyc(I, 0, R, 0); chk_b("b.pr1", 1, 4'h2, 1);
    cyc(I, 0, R, 0); chk_b("b.pr2", 1, 4'h3, 1);
    cyc(I, 0, R, 0); chk_b("b.pr3", 1, 4'h4, 0);

    // Random phase on dut_a: fill every word first so reads are defined.
    cyc(A, 4'h0, I, 0);
    for (int k = 0; k < 32; k++) begin
      cyc(W, 4'($urandom_range(0, 15)), I, 0);
    end
    for (int k = 0; k < 600; k++) begin
      rc = 2'($urandom_range(0, 3));
      rd = 4'($urandom_range(0, 15));
      cyc(rc, rd, I, 0);
      chk($sformatf("rnd%0d.valid", k), 32'(val_a), 32'(m_valid));
      chk($sformatf("rnd%0d.out", k),   32'(out_a), 32'(m_out));
      chk($sformatf("rnd%0d.busy", k),  32'(busy_a), 32'(m_cnt != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
